// File: rtl/iommu_wsi_ig.sv
`default_nettype none
// ============================================================================
// Module   : iommu_wsi_ig
// Purpose  : RISC-V IOMMU wire-signalled interrupt generator (CIP/FIP/PMIP
//            pending state plus vector-routed level outputs).
// Revision : 1.0 - initial release
// ============================================================================
module iommu_wsi_ig #(
  parameter int N_INT_VEC = 16,
  parameter int VEC_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wsi_en_i,
  input  logic                 cq_cond_i,
  input  logic                 cq_ie_i,
  input  logic                 fq_cond_i,
  input  logic                 fq_ie_i,
  input  logic                 pm_cond_i,
  input  logic                 pm_ie_i,
  input  logic [VEC_W-1:0]     civ_i,
  input  logic [VEC_W-1:0]     fiv_i,
  input  logic [VEC_W-1:0]     pmiv_i,
  input  logic [2:0]           ipsr_clr_i,
  output logic [2:0]           ipsr_o,
  output logic [2:0]           ipsr_set_o,
  output logic [N_INT_VEC-1:0] wsi_o
);

  logic [2:0]           w_trig;
  logic [2:0]           w_rise;
  logic [N_INT_VEC-1:0] w_req;
  logic [2:0]           r_prev;
  logic [2:0]           r_pend;
  logic [2:0]           r_set;
  logic [N_INT_VEC-1:0] r_wsi;

  assign w_trig = {pm_cond_i & pm_ie_i, fq_cond_i & fq_ie_i, cq_cond_i & cq_ie_i};
  assign w_rise = w_trig & ~r_prev;

  // Vectors at or above N_INT_VEC never match an index and so drop out.
  for (genvar v = 0; v < N_INT_VEC; v++) begin : g_vec
    assign w_req[v] = (r_pend[0] && (civ_i  == VEC_W'(v))) ||
                      (r_pend[1] && (fiv_i  == VEC_W'(v))) ||
                      (r_pend[2] && (pmiv_i == VEC_W'(v)));
  end

  // A hardware rise takes priority over a same-cycle software W1C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prev <= 3'b000;
      r_pend <= 3'b000;
      r_set  <= 3'b000;
      r_wsi  <= '0;
    end else begin
      r_prev <= w_trig;
      r_pend <= w_rise | (r_pend & ~ipsr_clr_i);
      r_set  <= w_rise;
      r_wsi  <= wsi_en_i ? w_req : '0;
    end
  end

  assign ipsr_o     = r_pend;
  assign ipsr_set_o = r_set;
  assign wsi_o      = r_wsi;

endmodule
`default_nettype wire

// File: tb/tb_iommu_wsi_ig.sv
`default_nettype none
// ============================================================================
// Module   : tb_iommu_wsi_ig
// Purpose  : Self-checking bench for iommu_wsi_ig (directed + random vs model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iommu_wsi_ig;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wsi_en = 1'b0;
  logic        cq_cond = 1'b0, cq_ie = 1'b0;
  logic        fq_cond = 1'b0, fq_ie = 1'b0;
  logic        pm_cond = 1'b0, pm_ie = 1'b0;
  logic [3:0]  civ = 4'd0, fiv = 4'd0, pmiv = 4'd0;
  logic [2:0]  clr = 3'b000;
  logic [2:0]  ipsr, ipsr_set, ipsr4, ipsr_set4;
  logic [15:0] wsi;
  logic [3:0]  wsi4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iommu_wsi_ig #(.N_INT_VEC(16), .VEC_W(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .wsi_en_i(wsi_en),
    .cq_cond_i(cq_cond), .cq_ie_i(cq_ie),
    .fq_cond_i(fq_cond), .fq_ie_i(fq_ie),
    .pm_cond_i(pm_cond), .pm_ie_i(pm_ie),
    .civ_i(civ), .fiv_i(fiv), .pmiv_i(pmiv),
    .ipsr_clr_i(clr), .ipsr_o(ipsr), .ipsr_set_o(ipsr_set), .wsi_o(wsi)
  );

  iommu_wsi_ig #(.N_INT_VEC(4), .VEC_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .wsi_en_i(wsi_en),
    .cq_cond_i(cq_cond), .cq_ie_i(cq_ie),
    .fq_cond_i(fq_cond), .fq_ie_i(fq_ie),
    .pm_cond_i(pm_cond), .pm_ie_i(pm_ie),
    .civ_i(civ), .fiv_i(fiv), .pmiv_i(pmiv),
    .ipsr_clr_i(clr), .ipsr_o(ipsr4), .ipsr_set_o(ipsr_set4), .wsi_o(wsi4)
  );

  // Reference model: per-source pending flags, wire word rebuilt by shifting.
  logic [2:0]  m_pend, m_prev, m_set;
  logic [15:0] m_wsi, m_wsi4;

  function automatic logic [15:0] route(input logic [2:0] p, input logic [3:0] v0,
                                        input logic [3:0] v1, input logic [3:0] v2,
                                        input int n);
    logic [15:0] r;
    int vec [3];
    r = 16'h0;
    vec[0] = int'(v0); vec[1] = int'(v1); vec[2] = int'(v2);
    for (int s = 0; s < 3; s++)
      if (p[s] && vec[s] < n) r = r | (16'h1 << vec[s]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 3'b000; m_prev <= 3'b000; m_set <= 3'b000;
      m_wsi  <= 16'h0;  m_wsi4 <= 16'h0;
    end else begin
      logic [2:0] trig, up;
      trig = {pm_cond && pm_ie, fq_cond && fq_ie, cq_cond && cq_ie};
      up   = 3'b000;
      for (int s = 0; s < 3; s++) up[s] = trig[s] && !m_prev[s];
      m_prev <= trig;
      m_set  <= up;
      for (int s = 0; s < 3; s++)
        m_pend[s] <= up[s] ? 1'b1 : (clr[s] ? 1'b0 : m_pend[s]);
      m_wsi  <= wsi_en ? route(m_pend, civ, fiv, pmiv, 16) : 16'h0;
      m_wsi4 <= wsi_en ? route(m_pend, civ, fiv, pmiv, 4)  : 16'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cq_cond = 0; fq_cond = 0; pm_cond = 0; clr = 3'b111;
    tick();
    clr = 3'b000;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1; cq_cond = 1; cq_ie = 1; wsi_en = 1; civ = 4'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({ipsr, ipsr_set, wsi} !== 22'h0) begin
        bad++;
        $display("FAIL reset_hold: ipsr=%b set=%b wsi=%h, need all 0", ipsr, ipsr_set, wsi);
      end
    end
    rst = 0;
    tick();
    total++;
    if (ipsr !== 3'b001 || ipsr_set !== 3'b001 || wsi !== 16'h0) begin
      bad++;
      $display("FAIL reset_rel1: ipsr=%b set=%b wsi=%h, need 001/001/0000", ipsr, ipsr_set, wsi);
    end
    tick();
    total++;
    if (wsi !== 16'h0008 || ipsr_set !== 3'b000) begin
      bad++;
      $display("FAIL reset_rel2: wsi=%h set=%b, need 0008/000", wsi, ipsr_set);
    end
  endtask

  task automatic test_w1c();
    clr = 3'b001;
    tick();
    clr = 3'b000;
    total++;
    if (ipsr !== 3'b000) begin
      bad++; $display("FAIL w1c_clear: ipsr=%b, need 000", ipsr);
    end
    tick();
    total++;
    if (wsi !== 16'h0 || ipsr !== 3'b000) begin
      bad++; $display("FAIL w1c_wire: wsi=%h ipsr=%b, need 0000/000", wsi, ipsr);
    end
    tick();
    total++;
    if (ipsr !== 3'b000) begin
      bad++; $display("FAIL w1c_noreset: ipsr=%b, need 000", ipsr);
    end
    cq_cond = 0;
    tick();
    cq_cond = 1;
    tick();
    total++;
    if (ipsr !== 3'b001 || ipsr_set !== 3'b001) begin
      bad++; $display("FAIL w1c_rearm: ipsr=%b set=%b, need 001/001", ipsr, ipsr_set);
    end
    tick();
    total++;
    if (wsi !== 16'h0008) begin
      bad++; $display("FAIL w1c_rearm_wire: wsi=%h, need 0008", wsi);
    end
    clear_all();
  endtask

  task automatic test_collision();
    fq_ie = 1; fiv = 4'd1; fq_cond = 1; clr = 3'b010;
    tick();
    clr = 3'b000;
    total++;
    if (ipsr !== 3'b010 || ipsr_set !== 3'b010) begin
      bad++; $display("FAIL collision: ipsr=%b set=%b, need 010/010", ipsr, ipsr_set);
    end
    clear_all();
  endtask

  task automatic test_shared();
    civ = 4'd5; fiv = 4'd5; cq_cond = 1; fq_cond = 1;
    tick(); tick();
    total++;
    if (ipsr !== 3'b011 || wsi !== 16'h0020) begin
      bad++; $display("FAIL shared_set: ipsr=%b wsi=%h, need 011/0020", ipsr, wsi);
    end
    clr = 3'b001;
    tick();
    clr = 3'b000;
    tick();
    total++;
    if (ipsr !== 3'b010 || wsi !== 16'h0020) begin
      bad++; $display("FAIL shared_cip: ipsr=%b wsi=%h, need 010/0020", ipsr, wsi);
    end
    clr = 3'b010;
    tick();
    clr = 3'b000;
    total++;
    if (ipsr !== 3'b000 || wsi !== 16'h0020) begin
      bad++; $display("FAIL shared_fip1: ipsr=%b wsi=%h, need 000/0020", ipsr, wsi);
    end
    tick();
    total++;
    if (wsi !== 16'h0) begin
      bad++; $display("FAIL shared_fip2: wsi=%h, need 0000", wsi);
    end
    clear_all();
  endtask

  task automatic test_enable_remap();
    wsi_en = 0; pm_ie = 1; pmiv = 4'd2; pm_cond = 1;
    tick(); tick();
    total++;
    if (ipsr !== 3'b100 || wsi !== 16'h0) begin
      bad++; $display("FAIL en_gate: ipsr=%b wsi=%h, need 100/0000", ipsr, wsi);
    end
    wsi_en = 1;
    tick();
    total++;
    if (wsi !== 16'h0004) begin
      bad++; $display("FAIL en_reassert: wsi=%h, need 0004", wsi);
    end
    pmiv = 4'd9;
    tick();
    total++;
    if (wsi !== 16'h0200) begin
      bad++; $display("FAIL remap: wsi=%h, need 0200", wsi);
    end
    pm_ie = 0;
    tick();
    total++;
    if (ipsr !== 3'b100) begin
      bad++; $display("FAIL ie_drop_keeps: ipsr=%b, need 100", ipsr);
    end
    pm_ie = 1;
    tick();
    total++;
    if (ipsr_set !== 3'b100) begin
      bad++; $display("FAIL ie_rerise: set=%b, need 100", ipsr_set);
    end
    clear_all();
  endtask

  task automatic test_unmapped();
    civ = 4'd7; cq_cond = 1;
    tick(); tick();
    total++;
    if (ipsr4 !== 3'b001 || wsi4 !== 4'h0 || wsi !== 16'h0080) begin
      bad++; $display("FAIL unmapped: ipsr4=%b wsi4=%h wsi=%h, need 001/0/0080", ipsr4, wsi4, wsi);
    end
    civ = 4'd2;
    tick();
    total++;
    if (wsi4 !== 4'h4) begin
      bad++; $display("FAIL unmapped_remap: wsi4=%h, need 4", wsi4);
    end
    clear_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      wsi_en  = ($urandom_range(0, 3) != 0);
      cq_cond = $urandom_range(0, 1); cq_ie = ($urandom_range(0, 3) != 0);
      fq_cond = $urandom_range(0, 1); fq_ie = ($urandom_range(0, 3) != 0);
      pm_cond = $urandom_range(0, 1); pm_ie = ($urandom_range(0, 3) != 0);
      civ  = 4'($urandom_range(0, 15));
      fiv  = 4'($urandom_range(0, 15));
      pmiv = 4'($urandom_range(0, 15));
      clr  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      tick();
      total++;
      if (ipsr !== m_pend || ipsr_set !== m_set || wsi !== m_wsi || {12'h0, wsi4} !== m_wsi4) begin
        bad++;
        $display("FAIL random[%0d]: ipsr=%b set=%b wsi=%h wsi4=%h, need %b/%b/%h/%h",
                 i, ipsr, ipsr_set, wsi, wsi4, m_pend, m_set, m_wsi, m_wsi4[3:0]);
      end
    end
    rst = 0; clr = 3'b000;
  endtask

  initial begin
    test_reset();
    test_w1c();
    test_collision();
    test_shared();
    test_enable_remap();
    test_unmapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
